// File: rtl/alu_mul_seq.sv
// Sequential unsigned shift-and-add multiplier.
// Borrows the CPU adder: one add per clock, W iterations per product.
module alu_mul_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [DATA_WIDTH-1:0]     i_op_a,
  input  logic [DATA_WIDTH-1:0]     i_op_b,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [2*DATA_WIDTH-1:0]   o_product,
  output logic                      o_high_nz,
  output logic [DATA_WIDTH-1:0]     o_adder_a,
  output logic [DATA_WIDTH-1:0]     o_adder_b,
  output logic                      o_adder_carry,
  output logic                      o_adder_neg_b,
  input  logic [DATA_WIDTH-1:0]     i_adder_result,
  input  logic                      i_adder_carry
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  m;
  logic [W-1:0]  p;
  logic [W-1:0]  q;
  logic [CW-1:0] cnt;
  logic          run;

  assign run = (state == S_RUN);

  // Control FSM and datapath: each RUN cycle folds in one multiplier bit
  // and shifts {carry, sum, Q} right, so the carry-out is never lost.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      m     <= '0;
      p     <= '0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            m     <= i_op_a;
            q     <= i_op_b;
            p     <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          p   <= {i_adder_carry, i_adder_result[W-1:1]};
          q   <= {i_adder_result[0], q[W-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Adder operands: partial high half plus the multiplicand when the
  // current multiplier bit is set; quiet outside RUN.
  always_comb begin
    o_adder_a = '0;
    o_adder_b = '0;
    if (run) begin
      o_adder_a = p;
      o_adder_b = q[0] ? m : '0;
    end
  end

  assign o_adder_carry = 1'b0;
  assign o_adder_neg_b = 1'b0;

  assign o_busy    = run;
  assign o_done    = (state == S_DONE);
  assign o_product = {p, q};
  assign o_high_nz = |p;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: external adder model, product/latency scoreboard
// and directed vectors with literal expectations.
module tb_alu_mul_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           high_nz;
  logic [W-1:0]   adder_a;
  logic [W-1:0]   adder_b;
  logic           adder_cin;
  logic           adder_neg;
  logic [W-1:0]   adder_r;
  logic           adder_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.DATA_WIDTH(W)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_op_a         (op_a),
    .i_op_b         (op_b),
    .o_busy         (busy),
    .o_done         (done),
    .o_product      (product),
    .o_high_nz      (high_nz),
    .o_adder_a      (adder_a),
    .o_adder_b      (adder_b),
    .o_adder_carry  (adder_cin),
    .o_adder_neg_b  (adder_neg),
    .i_adder_result (adder_r),
    .i_adder_carry  (adder_c)
  );

  // The CPU adder this block drives: plain combinational add.
  assign {adder_c, adder_r} = {1'b0, adder_a}
                            + {1'b0, (adder_neg ? ~adder_b : adder_b)}
                            + {{W{1'b0}}, adder_cin};

  task automatic chk(input string name, input longint act,
                     input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: an accepted start yields W busy cycles,
  // then one done cycle with product a*b, held until the next start.
  int             left;
  logic           m_done;
  longint         m_prod;
  longint         ma;
  longint         mb;
  logic           armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      left   <= 0;
      m_done <= 1'b0;
      m_prod <= 0;
      ma     <= 0;
      mb     <= 0;
      armed  <= 1'b1;
    end else if (left != 0) begin
      left <= left - 1;
      if (left == 1) begin
        m_done <= 1'b1;
        m_prod <= ma * mb;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        left <= W;
        ma   <= longint'(op_a);
        mb   <= longint'(op_b);
      end
    end
  end

  // Per-cycle compare. In iteration i the adder must see the partial
  // high half a*(b mod 2^i) >> i and addend b[i] ? a : 0.
  always @(negedge clk) begin
    if (armed) begin
      int     i;
      longint lowb;
      chk("busy", longint'(busy), longint'(left != 0));
      chk("done", longint'(done), longint'(m_done));
      chk("adder_cin", longint'(adder_cin), 0);
      chk("adder_neg", longint'(adder_neg), 0);
      if (left != 0) begin
        i    = W - left;
        lowb = mb & ((64'd1 << i) - 1);
        chk("run_adder_a", longint'(adder_a),
            ((ma * lowb) >> i) & ((64'd1 << W) - 1));
        chk("run_adder_b", longint'(adder_b), mb[i] ? ma : 0);
      end else begin
        chk("product", longint'(product), m_prod);
        chk("high_nz", longint'(high_nz),
            longint'((m_prod >> W) != 0));
        chk("idle_adder_a", longint'(adder_a), 0);
        chk("idle_adder_b", longint'(adder_b), 0);
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", longint'(busy), 1);
  endtask

  // Counts edges after the accepting edge until done is seen.
  task automatic wait_done(output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) return;
      if (busy) busy_n++;
    end
    chk("done_timeout", 0, 1);
  endtask

  int edges;
  int busy_n;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_product", longint'(product), 0);
    chk("rst_high_nz", longint'(high_nz), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 13*11
    start_op(8'd13, 8'd11);
    wait_done(edges, busy_n);
    chk("t1_latency", edges, W);
    chk("t1_busy_cycles", busy_n, W - 1);
    chk("t1_product", longint'(product), 16'h008F);
    chk("t1_high_nz", longint'(high_nz), 0);
    @(posedge clk);
    #1;
    chk("t1_done_pulse", longint'(done), 0);

    // 255*255: carries out of intermediate passes
    start_op(8'd255, 8'd255);
    wait_done(edges, busy_n);
    chk("t2_product", longint'(product), 16'hFE01);
    chk("t2_high_nz", longint'(high_nz), 1);
    @(posedge clk);
    #1;

    // zero operands
    start_op(8'd0, 8'd200);
    wait_done(edges, busy_n);
    chk("t3a_product", longint'(product), 0);
    chk("t3a_high_nz", longint'(high_nz), 0);
    @(posedge clk);
    #1;
    start_op(8'd200, 8'd0);
    wait_done(edges, busy_n);
    chk("t3b_product", longint'(product), 0);
    chk("t3b_high_nz", longint'(high_nz), 0);
    @(posedge clk);
    #1;

    // start during RUN ignored, then back-to-back start in DONE
    start_op(8'd13, 8'd11);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    op_a  = 8'd2;
    op_b  = 8'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = 8'd77;
    op_b  = 8'd99;
    wait_done(edges, busy_n);
    chk("t4_product", longint'(product), 16'h008F);
    start_op(8'd2, 8'd2);
    wait_done(edges, busy_n);
    chk("t4_done_gap", edges + 1, 9);
    chk("t4_product2", longint'(product), 16'h0004);
    @(posedge clk);
    #1;

    // reset mid-RUN discards the operation
    start_op(8'd255, 8'd255);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_busy", longint'(busy), 0);
    chk("t5_product", longint'(product), 0);
    chk("t5_done", longint'(done), 0);
    repeat (12) begin
      @(posedge clk);
      #1;
      chk("t5_no_done", longint'(done), 0);
    end
    start_op(8'd3, 8'd5);
    wait_done(edges, busy_n);
    chk("t5_product2", longint'(product), 16'h000F);
    @(posedge clk);
    #1;

    // product hold with noisy operand inputs
    start_op(8'd13, 8'd11);
    wait_done(edges, busy_n);
    repeat (20) begin
      op_a = W'($urandom);
      op_b = W'($urandom);
      @(posedge clk);
      #1;
    end
    chk("t6_product", longint'(product), 16'h008F);
    chk("t6_adder_a", longint'(adder_a), 0);
    chk("t6_adder_b", longint'(adder_b), 0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
